// File: rtl/ramsdp_pipe.sv
// Simple dual-port RAM: masked write port A, read port B with 1/2-cycle latency,
// optional same-address write bypass and a one-cycle read-valid strobe.
module ramsdp_pipe #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 6,
  parameter int unsigned BW     = 8,
  parameter int unsigned RDLAT  = 1,
  parameter int unsigned BYPASS = 0
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en_a,
  input  logic             we_a,
  input  logic [DW/BW-1:0] wmask_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [DW-1:0]    din_a,
  input  logic             en_b,
  input  logic [AW-1:0]    addr_b,
  output logic [DW-1:0]    dout_b,
  output logic             valid_b
);

  localparam int unsigned NL    = DW / BW;
  localparam int unsigned Depth = 2 ** AW;

  if (DW % BW != 0) begin : g_bad_bw
    $error("ramsdp_pipe: DW must be a multiple of BW");
  end
  if (RDLAT != 1 && RDLAT != 2) begin : g_bad_rdlat
    $error("ramsdp_pipe: RDLAT must be 1 or 2");
  end

  logic [DW-1:0] mem [Depth];
  logic          wr_en;
  logic [DW-1:0] rd_word;
  logic          stage_v;
  logic [DW-1:0] stage_d;

  // Writes are suppressed while reset is held, even though the array has no reset.
  assign wr_en = nreset & en_a & we_a;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NL; i++) begin
        if (wmask_a[i]) mem[addr_a][i*BW +: BW] <= din_a[i*BW +: BW];
      end
    end
  end

  always_comb begin
    rd_word = mem[addr_b];
    if (BYPASS != 0 && wr_en && addr_a == addr_b) begin
      for (int i = 0; i < NL; i++) begin
        if (wmask_a[i]) rd_word[i*BW +: BW] = din_a[i*BW +: BW];
      end
    end
  end

  if (RDLAT == 2) begin : g_lat2
    logic          pipe_v;
    logic [DW-1:0] pipe_d;

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        pipe_v <= 1'b0;
        pipe_d <= '0;
      end else begin
        pipe_v <= en_b;
        if (en_b) pipe_d <= rd_word;
      end
    end

    assign stage_v = pipe_v;
    assign stage_d = pipe_d;
  end else begin : g_lat1
    assign stage_v = en_b;
    assign stage_d = rd_word;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_b <= 1'b0;
      dout_b  <= '0;
    end else begin
      valid_b <= stage_v;
      if (stage_v) dout_b <= stage_d;
    end
  end

endmodule
